// File: rtl/path_stream_pkg.sv
// Shared constants for the path result streamer: beat kinds, sentinel words
// and FSM state encodings.
package path_stream_pkg;

    // Beat kind tags carried on out_kind
    localparam logic [1:0] KIND_HOP     = 2'b00;
    localparam logic [1:0] KIND_UNREACH = 2'b01;
    localparam logic [1:0] KIND_TERM    = 2'b10;
    localparam logic [1:0] KIND_NEGCYC  = 2'b11;

    // Sentinel words written by the Bellman-Ford core
    localparam logic [15:0] TERM_WORD    = 16'h0000;
    localparam logic [15:0] UNREACH_WORD = 16'hFFFF;

    // Walker FSM state encodings
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ISSUE   = 3'd1;
    localparam state_t ST_CAPTURE = 3'd2;
    localparam state_t ST_EMIT    = 3'd3;
    localparam state_t ST_FINISH  = 3'd4;

endpackage

// File: rtl/path_result_streamer.sv
// Walks the shortest-path result RAM from a base address and streams each
// entry, tagged by kind, over valid/ready until the terminator word. A
// negative-cycle flag replaces the walk with a single status beat.
module path_result_streamer
    import path_stream_pkg::*;
#(
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_ENTRIES = 16383
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  n_exist,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_kind,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  truncated,
    output logic [ADDR_WIDTH-1:0] entry_count
);

    localparam logic [ADDR_WIDTH-1:0] CAP_IDX = ADDR_WIDTH'(MAX_ENTRIES - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  is_term;
    logic                  is_unreach;
    logic                  at_cap;

    // Classify the word returned by the RAM and detect the walk cap
    always_comb begin
        is_term    = (mem_rdata == DATA_WIDTH'(TERM_WORD));
        is_unreach = (mem_rdata == DATA_WIDTH'(UNREACH_WORD));
        at_cap     = (idx == CAP_IDX);
    end

    // Walker FSM and registered output beat
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            base_r      <= '0;
            idx         <= '0;
            out_data    <= '0;
            out_kind    <= KIND_HOP;
            out_last    <= 1'b0;
            entry_count <= '0;
            truncated   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_r      <= base_addr;
                        idx         <= '0;
                        entry_count <= '0;
                        truncated   <= 1'b0;
                        if (n_exist) begin
                            out_data <= '0;
                            out_kind <= KIND_NEGCYC;
                            out_last <= 1'b1;
                            state    <= ST_EMIT;
                        end else begin
                            state    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    out_data <= mem_rdata;
                    if (is_term) begin
                        out_kind <= KIND_TERM;
                        out_last <= 1'b1;
                    end else begin
                        out_kind <= is_unreach ? KIND_UNREACH : KIND_HOP;
                        out_last <= at_cap;
                        if (at_cap) begin
                            truncated <= 1'b1;
                        end
                    end
                    state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        entry_count <= entry_count + 1'b1;
                        if (out_last) begin
                            state <= ST_FINISH;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes decoded from state; address wraps naturally at ADDR_WIDTH bits
    always_comb begin
        mem_rd_en = (state == ST_ISSUE);
        mem_addr  = base_r + idx;
        out_valid = (state == ST_EMIT);
        busy      = (state == ST_ISSUE) || (state == ST_CAPTURE) || (state == ST_EMIT);
        done      = (state == ST_FINISH);
    end

endmodule

// File: tb/tb_path_result_streamer.sv
// Self-checking bench for path_result_streamer: directed scenarios plus
// randomized paths, checked against a queue-based model of the walk.
module tb_path_result_streamer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        n_exist;
    logic [13:0] base_addr;
    logic        mem_rd_en;
    logic [13:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_kind;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        truncated;
    logic [13:0] entry_count;

    // Second instance with a tiny walk cap
    logic        c_start;
    logic        c_rd_en;
    logic [13:0] c_addr;
    logic [15:0] c_rdata = 16'h0000;
    logic        c_valid;
    logic        c_ready;
    logic [15:0] c_data;
    logic [1:0]  c_kind;
    logic        c_last;
    logic        c_busy;
    logic        c_done;
    logic        c_trunc;
    logic [13:0] c_count;

    logic [15:0] mem [0:16383];

    int ncmp  = 0;
    int nfail = 0;

    logic [18:0] exp_q [$];
    logic [13:0] addr_q [$];
    logic        exp_trunc;

    path_result_streamer dut (
        .clock(clock), .reset(reset), .start(start), .n_exist(n_exist),
        .base_addr(base_addr), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_kind(out_kind), .out_last(out_last),
        .busy(busy), .done(done), .truncated(truncated), .entry_count(entry_count)
    );

    path_result_streamer #(.MAX_ENTRIES(4)) dut_cap (
        .clock(clock), .reset(reset), .start(c_start), .n_exist(1'b0),
        .base_addr(14'h0100), .mem_rd_en(c_rd_en), .mem_addr(c_addr),
        .mem_rdata(c_rdata), .out_valid(c_valid), .out_ready(c_ready),
        .out_data(c_data), .out_kind(c_kind), .out_last(c_last),
        .busy(c_busy), .done(c_done), .truncated(c_trunc), .entry_count(c_count)
    );

    always #5 clock = ~clock;

    // 1-cycle synchronous read RAMs
    always @(posedge clock) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (c_rd_en)   c_rdata   <= 16'h0009;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference walk: list of beats {data,kind,last} and read addresses
    function automatic void build_model(input logic [13:0] base, input bit neg, input int max);
        logic [13:0] a;
        logic [15:0] w;
        logic [1:0]  k;
        bit          last;
        exp_q.delete();
        addr_q.delete();
        exp_trunc = 1'b0;
        if (neg) begin
            exp_q.push_back({16'h0000, 2'b11, 1'b1});
            return;
        end
        for (int i = 0; i < max; i++) begin
            a = base + 14'(i);
            w = mem[a];
            addr_q.push_back(a);
            k    = (w == 16'h0000) ? 2'b10 : (w == 16'hFFFF) ? 2'b01 : 2'b00;
            last = (w == 16'h0000) || (i == max - 1);
            if (w != 16'h0000 && i == max - 1) exp_trunc = 1'b1;
            exp_q.push_back({w, k, last});
            if (last) break;
        end
    endfunction

    task automatic check_all_zero(input string name);
        check({name, " rd_en"},  mem_rd_en,   0);
        check({name, " addr"},   mem_addr,    0);
        check({name, " valid"},  out_valid,   0);
        check({name, " data"},   out_data,    0);
        check({name, " kind"},   out_kind,    0);
        check({name, " last"},   out_last,    0);
        check({name, " busy"},   busy,        0);
        check({name, " done"},   done,        0);
        check({name, " trunc"},  truncated,   0);
        check({name, " count"},  entry_count, 0);
    endtask

    task automatic run_walk(input logic [13:0] base, input bit neg, input int ready_pct,
                            input int hold_beat, input string name);
        int beats = 0;
        int ndone = 0;
        int hold  = 0;
        int nexp;
        build_model(base, neg, 16383);
        nexp      = exp_q.size();
        base_addr = base;
        n_exist   = neg;
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clock); #1;
        start     = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            base_addr = 14'($urandom);
            n_exist   = 1'($urandom);
            if (mem_rd_en) begin
                if (addr_q.size() == 0) check({name, " unexpected_read"}, 1, 0);
                else                    check({name, " addr"}, mem_addr, addr_q.pop_front());
            end
            if (out_valid) begin
                check({name, " busy_in_emit"}, busy, 1);
                if (exp_q.size() == 0) check({name, " unexpected_beat"}, 1, 0);
                else check({name, " beat"}, {out_data, out_kind, out_last}, exp_q[0]);
                if (beats == hold_beat && hold < 5) begin
                    out_ready = 1'b0;
                    hold++;
                end else begin
                    out_ready = ($urandom_range(0, 99) < ready_pct);
                end
                if (out_ready) begin
                    beats++;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end else begin
                out_ready = 1'($urandom);
            end
            if (done) begin
                ndone++;
                break;
            end
            start = busy && ($urandom_range(0, 3) == 0);
            @(posedge clock); #1;
        end
        start = 1'b0;
        check({name, " done_seen"}, ndone, 1);
        check({name, " busy_at_done"}, busy, 0);
        check({name, " valid_at_done"}, out_valid, 0);
        check({name, " beats_left"}, exp_q.size(), 0);
        check({name, " reads_left"}, addr_q.size(), 0);
        if (!neg) begin
            check({name, " entry_count"}, entry_count, nexp);
            check({name, " truncated"}, truncated, exp_trunc);
        end
        @(posedge clock); #1;
        check({name, " done_pulse"}, done, 0);
    endtask

    initial begin
        logic [13:0] b;
        logic [15:0] w;
        int          len;
        int          c_beats;
        int          c_reads;
        int          c_dones;

        reset     = 1'b1;
        start     = 1'b0;
        n_exist   = 1'b0;
        base_addr = '0;
        out_ready = 1'b0;
        c_start   = 1'b0;
        c_ready   = 1'b1;
        for (int i = 0; i < 16384; i++) mem[i] = 16'h1234;

        #3;
        check_all_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;

        // Basic walk
        mem[1] = 16'h0005; mem[2] = 16'h0003; mem[3] = 16'h0000;
        run_walk(14'd1, 1'b0, 100, -1, "basic");

        // Unreachable entry
        mem[1] = 16'hFFFF; mem[2] = 16'h0000;
        run_walk(14'd1, 1'b0, 100, -1, "unreach");

        // Negative cycle status beat
        run_walk(14'($urandom), 1'b1, 100, -1, "negcyc");

        // Backpressure on beat 2 of the basic walk
        mem[1] = 16'h0005; mem[2] = 16'h0003; mem[3] = 16'h0000;
        run_walk(14'd1, 1'b0, 100, 1, "backpressure");

        // Address wrap
        mem[14'h3FFF] = 16'h0007; mem[0] = 16'h0000;
        run_walk(14'h3FFF, 1'b0, 100, -1, "wrap");

        // Randomized paths with random backpressure
        for (int t = 0; t < 12; t++) begin
            b   = 14'($urandom);
            len = $urandom_range(0, 10);
            for (int k = 0; k < len; k++) begin
                w = 16'($urandom);
                if (w == 16'h0000) w = 16'h0001;
                if ($urandom_range(0, 4) == 0) w = 16'hFFFF;
                mem[b + 14'(k)] = w;
            end
            mem[b + 14'(len)] = 16'h0000;
            run_walk(b, 1'b0, 70, $urandom_range(0, 3), "random");
        end

        // Reset during EMIT
        mem[1] = 16'h0005; mem[2] = 16'h0003; mem[3] = 16'h0000;
        base_addr = 14'd1;
        n_exist   = 1'b0;
        start     = 1'b1;
        @(posedge clock); #1;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clock); #1;
        end
        check("midreset reached_emit", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("midreset no_done", done, 0);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        run_walk(14'd1, 1'b0, 100, -1, "restart");

        // Walk cap on the MAX_ENTRIES=4 instance
        c_beats = 0;
        c_reads = 0;
        c_dones = 0;
        c_start = 1'b1;
        @(posedge clock); #1;
        c_start = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (c_rd_en) c_reads++;
            if (c_valid) begin
                c_beats++;
                check("cap beat", {c_data, c_kind, c_last}, {16'h0009, 2'b00, (c_beats == 4)});
            end
            if (c_done) begin
                c_dones++;
                break;
            end
            @(posedge clock); #1;
        end
        check("cap done_seen", c_dones, 1);
        check("cap beats", c_beats, 4);
        check("cap reads", c_reads, 4);
        check("cap truncated", c_trunc, 1);
        check("cap entry_count", c_count, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
